// File: rtl/switch_pkg.sv
// Shared types and constants for the switch routing path.
package switch_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned DW        = 8;
  localparam int unsigned HDR_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE,
    F_SRC,
    F_LEN,
    F_PAY,
    D_SRC,
    D_LEN,
    D_PAY
  } route_state_t;

endpackage

// File: rtl/port_addr_regs.sv
// Programmable per-port destination address registers with a registered
// read port and a combinational match vector against the lookup byte.
module port_addr_regs #(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned Dw       = 8,
  parameter int unsigned Aw       = $clog2(NumPorts)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_en_i,
  input  logic                cfg_wr_i,
  input  logic [Aw-1:0]       cfg_addr_i,
  input  logic [Dw-1:0]       cfg_wdata_i,
  output logic [Dw-1:0]       cfg_rdata_o,
  input  logic [Dw-1:0]       lookup_i,
  output logic [NumPorts-1:0] match_o
);

  logic [Dw-1:0] regs_q [NumPorts];
  logic [Dw-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumPorts); i++) begin
        regs_q[i] <= Dw'(i);
      end
      rdata_q <= '0;
    end else if (cfg_en_i) begin
      if (cfg_wr_i) begin
        regs_q[cfg_addr_i] <= cfg_wdata_i;
      end else begin
        rdata_q <= regs_q[cfg_addr_i];
      end
    end
  end

  // Compares against the pre-edge contents, so a same-cycle write is not seen.
  always_comb begin
    match_o = '0;
    for (int i = 0; i < int'(NumPorts); i++) begin
      match_o[i] = (regs_q[i] == lookup_i);
    end
  end

  assign cfg_rdata_o = rdata_q;

endmodule

// File: rtl/pkt_route_ctrl.sv
// Packet routing controller: header lookup, forward/drop sequencing,
// FIFO back-pressure and saturating packet counters.
module pkt_route_ctrl #(
  parameter int unsigned NUM_PORTS = switch_pkg::NUM_PORTS,
  parameter int unsigned DW        = switch_pkg::DW,
  parameter int unsigned CW        = 16
) (
  input  logic                         fast_clk,
  input  logic                         reset,
  input  logic                         cfg_en,
  input  logic                         cfg_rd_wr,
  input  logic [$clog2(NUM_PORTS)-1:0] cfg_addr,
  input  logic [DW-1:0]                cfg_wdata,
  output logic [DW-1:0]                cfg_rdata,
  input  logic                         in_valid,
  input  logic [DW-1:0]                in_data,
  output logic                         in_stall,
  input  logic [NUM_PORTS-1:0]         fifo_full,
  output logic [NUM_PORTS-1:0]         fifo_wr_en,
  output logic [DW-1:0]                fifo_wdata,
  output logic [CW-1:0]                fwd_cnt,
  output logic [CW-1:0]                drop_cnt,
  output logic                         busy
);

  import switch_pkg::*;

  localparam int unsigned AW = $clog2(NUM_PORTS);

  route_state_t         state_q;
  logic [AW-1:0]        sel_q;
  logic [7:0]           rem_q;
  logic [CW-1:0]        fwd_q;
  logic [CW-1:0]        drop_q;

  logic [NUM_PORTS-1:0] match;
  logic                 hit;
  logic [AW-1:0]        hit_idx;
  logic                 fwd_state;
  logic                 accept;
  logic [AW-1:0]        wr_port;
  logic                 fwd_beat;
  logic [7:0]           len_byte;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  port_addr_regs #(
    .NumPorts(NUM_PORTS),
    .Dw      (DW),
    .Aw      (AW)
  ) u_addr_regs (
    .clk_i      (fast_clk),
    .rst_i      (reset),
    .cfg_en_i   (cfg_en),
    .cfg_wr_i   (cfg_rd_wr),
    .cfg_addr_i (cfg_addr),
    .cfg_wdata_i(cfg_wdata),
    .cfg_rdata_o(cfg_rdata),
    .lookup_i   (in_data),
    .match_o    (match)
  );

  // Lowest matching index wins, hence the descending scan.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end

  assign fwd_state = (state_q == F_SRC) || (state_q == F_LEN) || (state_q == F_PAY);

  always_comb begin
    in_stall = 1'b0;
    case (state_q)
      IDLE:               in_stall = hit && fifo_full[hit_idx];
      F_SRC, F_LEN, F_PAY: in_stall = fifo_full[sel_q];
      default:            in_stall = 1'b0;
    endcase
  end

  assign accept     = in_valid && !in_stall;
  assign wr_port    = (state_q == IDLE) ? hit_idx : sel_q;
  assign fwd_beat   = accept && !reset && ((state_q == IDLE) ? hit : fwd_state);
  assign fifo_wr_en = fwd_beat ? (NUM_PORTS'(1) << wr_port) : '0;
  assign fifo_wdata = in_data;
  assign len_byte   = in_data[7:0];

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rem_q   <= '0;
      fwd_q   <= '0;
      drop_q  <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            state_q <= F_SRC;
            sel_q   <= hit_idx;
          end else begin
            state_q <= D_SRC;
          end
        end
        F_SRC: state_q <= F_LEN;
        D_SRC: state_q <= D_LEN;
        F_LEN, D_LEN: begin
          rem_q <= len_byte;
          if (len_byte == 8'd0) begin
            state_q <= IDLE;
            if (state_q == F_LEN) fwd_q <= sat_inc(fwd_q);
            else                  drop_q <= sat_inc(drop_q);
          end else begin
            state_q <= (state_q == F_LEN) ? F_PAY : D_PAY;
          end
        end
        F_PAY, D_PAY: begin
          rem_q <= rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_q <= IDLE;
            if (state_q == F_PAY) fwd_q <= sat_inc(fwd_q);
            else                  drop_q <= sat_inc(drop_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fwd_cnt  = fwd_q;
  assign drop_cnt = drop_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pkt_route_ctrl.sv
// Directed plus randomized bench for pkt_route_ctrl with a byte-position
// packet model.
module tb_pkt_route_ctrl;

  logic        fast_clk = 1'b0;
  logic        reset;
  logic        cfg_en;
  logic        cfg_rd_wr;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [7:0]  cfg_rdata;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_stall;
  logic [3:0]  fifo_full;
  logic [3:0]  fifo_wr_en;
  logic [7:0]  fifo_wdata;
  logic [15:0] fwd_cnt;
  logic [15:0] drop_cnt;
  logic        busy;

  always #5 fast_clk = ~fast_clk;

  pkt_route_ctrl #(
    .NUM_PORTS(4),
    .DW       (8),
    .CW       (16)
  ) dut (
    .fast_clk  (fast_clk),
    .reset     (reset),
    .cfg_en    (cfg_en),
    .cfg_rd_wr (cfg_rd_wr),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_stall  (in_stall),
    .fifo_full (fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata),
    .fwd_cnt   (fwd_cnt),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the current packet, its length and target.
  logic [7:0] m_addr [4];
  int         m_pos;
  int         m_len;
  int         m_dest;
  int         m_fwd;
  int         m_drop;
  logic [7:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int lookup(input logic [7:0] d);
    for (int i = 0; i < 4; i++) begin
      if (m_addr[i] === d) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pos   = 0;
    m_len   = 0;
    m_dest  = -1;
    m_fwd   = 0;
    m_drop  = 0;
    m_rdata = 8'h00;
    for (int i = 0; i < 4; i++) m_addr[i] = 8'(i);
  endtask

  // One clock: drive after negedge, check combinational outputs, then state after posedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [3:0] full,
                       input logic ce, input logic rw, input logic [1:0] a,
                       input logic [7:0] wd, output bit acc);
    int         port;
    logic       exp_stall;
    logic [3:0] exp_wr;
    in_valid  = v;
    in_data   = d;
    fifo_full = full;
    cfg_en    = ce;
    cfg_rd_wr = rw;
    cfg_addr  = a;
    cfg_wdata = wd;
    #1;
    port      = (m_pos == 0) ? lookup(d) : m_dest;
    exp_stall = (port >= 0) && full[port];
    acc       = v && !exp_stall;
    exp_wr    = (acc && port >= 0) ? 4'(1 << port) : 4'b0000;
    chk("in_stall", 32'(in_stall), 32'(exp_stall));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
    chk("fifo_wdata", 32'(fifo_wdata), 32'(d));
    @(posedge fast_clk);
    if (ce) begin
      if (rw) m_addr[a] = wd;
      else    m_rdata   = m_addr[a];
    end
    if (acc) begin
      if (m_pos == 0) begin
        m_dest = port;
        m_pos  = 1;
      end else if (m_pos == 1) begin
        m_pos = 2;
      end else begin
        if (m_pos == 2) m_len = int'(d);
        m_pos++;
        if (m_pos == 3 + m_len) begin
          if (m_dest >= 0) m_fwd++;
          else             m_drop++;
          m_pos = 0;
        end
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(m_pos != 0));
    chk("fwd_cnt", 32'(fwd_cnt), 32'(m_fwd));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("cfg_rdata", 32'(cfg_rdata), 32'(m_rdata));
    @(negedge fast_clk);
  endtask

  task automatic idle_cfg(input logic rw, input logic [1:0] a, input logic [7:0] wd);
    bit acc;
    cycle(1'b0, 8'hFF, 4'b0000, 1'b1, rw, a, wd, acc);
  endtask

  task automatic send_pkt(input logic [7:0] pkt[$], input bit rnd);
    foreach (pkt[k]) begin
      bit acc = 0;
      int n   = 0;
      while (!acc && n < 200) begin
        logic       v;
        logic [3:0] full;
        logic       ce;
        v    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        full = rnd ? (4'($urandom) & 4'($urandom)) : 4'b0000;
        ce   = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
        cycle(v, pkt[k], full, ce, 1'($urandom), 2'($urandom),
              8'($urandom_range(0, 7)), acc);
        n++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = m_addr[1];
    fifo_full = 4'b0000;
    cfg_en    = 1'b0;
    #1;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    @(posedge fast_clk);
    model_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fwd", 32'(fwd_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_rdata", 32'(cfg_rdata), 32'd0);
    @(negedge fast_clk);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    bit         acc;
    reset     = 1'b1;
    cfg_en    = 1'b0;
    cfg_rd_wr = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = 8'h00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    fifo_full = 4'b0000;
    model_reset();
    @(negedge fast_clk);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      idle_cfg(1'b0, 2'(i), 8'h00);
      chk("cfg_read_default", 32'(cfg_rdata), i);
    end

    idle_cfg(1'b1, 2'd2, 8'hA5);
    q = {8'hA5, 8'h11, 8'h02, 8'hDE, 8'hAD};
    send_pkt(q, 0);
    chk("fwd_a5", 32'(fwd_cnt), 32'd1);

    q = {8'h77, 8'h11, 8'h01, 8'h55};
    send_pkt(q, 0);
    chk("drop_77", 32'(drop_cnt), 32'd1);

    q = {8'h01, 8'h11, 8'h04, 8'hC0};
    send_pkt(q, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'hC1, 4'b0010, 1'b0, 1'b0, 2'd0, 8'h00, acc);
      chk("stall_port1", 32'(acc), 32'd0);
    end
    q = {8'hC1, 8'hC2, 8'hC3};
    send_pkt(q, 0);
    chk("fwd_after_stall", 32'(fwd_cnt), 32'd2);

    idle_cfg(1'b1, 2'd0, 8'h20);
    idle_cfg(1'b1, 2'd3, 8'h20);
    q = {8'h20, 8'hAA, 8'h01, 8'hBB};
    send_pkt(q, 0);
    q = {8'h20, 8'hAA, 8'h03};
    send_pkt(q, 0);
    cycle(1'b1, 8'h31, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h33, acc);
    chk("midpkt_write_port0", 32'(acc), 32'd1);
    q = {8'h32, 8'h33};
    send_pkt(q, 0);
    chk("fwd_dup_addr", 32'(fwd_cnt), 32'd4);

    do_reset();
    // Lookup and write to the same register in one cycle: lookup sees old value.
    cycle(1'b1, 8'h02, 4'b0000, 1'b1, 1'b1, 2'd2, 8'h99, acc);
    q = {8'h11, 8'h00};
    send_pkt(q, 0);
    chk("same_cycle_lookup", 32'(fwd_cnt), 32'd1);

    q = {8'h03, 8'h11, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(q, 0);
    chk("midpkt_busy", 32'(busy), 32'd1);
    do_reset();
    q = {8'h03, 8'h00, 8'h00};
    send_pkt(q, 0);
    chk("zero_len_fwd", 32'(fwd_cnt), 32'd1);
    chk("zero_len_idle", 32'(busy), 32'd0);

    for (int p = 0; p < 40; p++) begin
      int len;
      q.delete();
      len = $urandom_range(0, 10);
      q.push_back(8'($urandom_range(0, 7)));
      q.push_back(8'($urandom));
      q.push_back(8'(len));
      for (int b = 0; b < len; b++) q.push_back(8'($urandom));
      send_pkt(q, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
